// File: rtl/alu_mdu.sv
// Integer ALU with iterative multiply/divide behind a valid/ready handshake.
// Optional macro ALU_MDU_FAST_MUL_EN: single-cycle array multiplier; division stays iterative.
module alu_mdu #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [18:0]       alu_op,
  input  logic [DATA_W-1:0] alu_src1,
  input  logic [DATA_W-1:0] alu_src2,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] alu_result,
  output logic              div_by_zero,
  output logic              busy
);

  localparam int SHAMT_W = $clog2(DATA_W);
  localparam int W2      = 2 * DATA_W;
  localparam int unsigned LAST_I = DATA_W - 1;
  localparam logic [SHAMT_W:0] CNT_LAST = LAST_I[SHAMT_W:0];
  localparam logic [SHAMT_W:0] CNT_ONE  = {{SHAMT_W{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_r, state_nx;

  logic [DATA_W-1:0]  result_r;
  logic               dbz_r;
  logic [SHAMT_W:0]   cnt_r;
  logic [6:0]         kind_r;
  logic               qneg_r, rneg_r;
  logic [W2-1:0]      acc_r, opa_r;
  logic [DATA_W-1:0]  opb_r;

  logic               accept_s, is_iter_s, dbz_req_s, go_calc_s, is_mul_req_s;
  logic [SHAMT_W-1:0] shamt_s;
  logic               slt_s, sltu_s;
  logic [DATA_W-1:0]  base_res_s, single_res_s;
  logic               use_sign_s, sdiv_s;
  logic [DATA_W-1:0]  mag1_s, mag2_s;
  logic [W2-1:0]      mul_acc_nx_s, div_acc_nx_s, acc_nx_s, prod_s;
  logic [DATA_W:0]    rem_sh_s, rem_diff_s;
  logic               qbit_s, step_mul_s;
  logic [DATA_W-1:0]  rem_nx_s, quo_s, rem_s, quo_sgn_s, rem_sgn_s, iter_res_s;
`ifdef ALU_MDU_FAST_MUL_EN
  logic [W2-1:0]      fm_ss_s, fm_uu_s;
`endif

  assign in_ready    = (state_r == IDLE) | ((state_r == DONE) & out_ready);
  assign out_valid   = (state_r == DONE);
  assign busy        = (state_r == CALC);
  assign alu_result  = result_r;
  assign div_by_zero = dbz_r;
  assign accept_s    = in_valid & in_ready;

  // Request decode, single-cycle results and operand magnitudes
  always_comb begin
    shamt_s      = alu_src2[SHAMT_W-1:0];
    slt_s        = $signed(alu_src1) < $signed(alu_src2);
    sltu_s       = alu_src1 < alu_src2;
    dbz_req_s    = (|alu_op[18:15]) & (alu_src2 == {DATA_W{1'b0}});
    is_mul_req_s = |alu_op[14:12];
    base_res_s   = ({DATA_W{alu_op[0]}}  & (alu_src1 + alu_src2))
                 | ({DATA_W{alu_op[1]}}  & (alu_src1 - alu_src2))
                 | ({DATA_W{alu_op[2]}}  & {{(DATA_W-1){1'b0}}, slt_s})
                 | ({DATA_W{alu_op[3]}}  & {{(DATA_W-1){1'b0}}, sltu_s})
                 | ({DATA_W{alu_op[4]}}  & (alu_src1 & alu_src2))
                 | ({DATA_W{alu_op[5]}}  & ~(alu_src1 | alu_src2))
                 | ({DATA_W{alu_op[6]}}  & (alu_src1 | alu_src2))
                 | ({DATA_W{alu_op[7]}}  & (alu_src1 ^ alu_src2))
                 | ({DATA_W{alu_op[8]}}  & (alu_src1 << shamt_s))
                 | ({DATA_W{alu_op[9]}}  & (alu_src1 >> shamt_s))
                 | ({DATA_W{alu_op[10]}} & $unsigned($signed(alu_src1) >>> shamt_s))
                 | ({DATA_W{alu_op[11]}} & {alu_src2[DATA_W-1:12], 12'h000});
`ifdef ALU_MDU_FAST_MUL_EN
    // Sign-extended operands give the signed product in the low 2*DATA_W bits
    fm_ss_s    = {{DATA_W{alu_src1[DATA_W-1]}}, alu_src1} * {{DATA_W{alu_src2[DATA_W-1]}}, alu_src2};
    fm_uu_s    = {{DATA_W{1'b0}}, alu_src1} * {{DATA_W{1'b0}}, alu_src2};
    base_res_s = base_res_s
               | ({DATA_W{alu_op[12]}} & fm_uu_s[DATA_W-1:0])
               | ({DATA_W{alu_op[13]}} & fm_ss_s[W2-1:DATA_W])
               | ({DATA_W{alu_op[14]}} & fm_uu_s[W2-1:DATA_W]);
    is_iter_s  = |alu_op[18:15];
`else
    is_iter_s  = |alu_op[18:12];
`endif
    go_calc_s  = is_iter_s & ~dbz_req_s;
    if (dbz_req_s) begin
      single_res_s = (alu_op[15] | alu_op[17]) ? {DATA_W{1'b1}} : alu_src1;
    end else begin
      single_res_s = base_res_s;
    end
    sdiv_s     = alu_op[15] | alu_op[16];
    use_sign_s = alu_op[13] | sdiv_s;
    mag1_s     = (use_sign_s & alu_src1[DATA_W-1]) ? -alu_src1 : alu_src1;
    mag2_s     = (use_sign_s & alu_src2[DATA_W-1]) ? -alu_src2 : alu_src2;
  end

  // One shift-add or restoring-divide step plus final sign fix-up
  always_comb begin
    step_mul_s   = |kind_r[2:0];
    mul_acc_nx_s = opb_r[0] ? (acc_r + opa_r) : acc_r;
    rem_sh_s     = {acc_r[W2-1:DATA_W], acc_r[DATA_W-1]};
    rem_diff_s   = rem_sh_s - {1'b0, opb_r};
    qbit_s       = ~rem_diff_s[DATA_W];
    if (qbit_s) begin
      rem_nx_s = rem_diff_s[DATA_W-1:0];
    end else begin
      rem_nx_s = rem_sh_s[DATA_W-1:0];
    end
    div_acc_nx_s = {rem_nx_s, acc_r[DATA_W-2:0], qbit_s};
    acc_nx_s     = step_mul_s ? mul_acc_nx_s : div_acc_nx_s;
    prod_s       = qneg_r ? -mul_acc_nx_s : mul_acc_nx_s;
    quo_s        = div_acc_nx_s[DATA_W-1:0];
    rem_s        = div_acc_nx_s[W2-1:DATA_W];
    quo_sgn_s    = qneg_r ? -quo_s : quo_s;
    rem_sgn_s    = rneg_r ? -rem_s : rem_s;
    iter_res_s   = ({DATA_W{kind_r[0]}} & mul_acc_nx_s[DATA_W-1:0])
                 | ({DATA_W{kind_r[1]}} & prod_s[W2-1:DATA_W])
                 | ({DATA_W{kind_r[2]}} & mul_acc_nx_s[W2-1:DATA_W])
                 | ({DATA_W{kind_r[3]}} & quo_sgn_s)
                 | ({DATA_W{kind_r[4]}} & rem_sgn_s)
                 | ({DATA_W{kind_r[5]}} & quo_s)
                 | ({DATA_W{kind_r[6]}} & rem_s);
  end

  // State register
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx;
    end
  end

  // Next-state logic
  always_comb begin
    state_nx = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_nx = go_calc_s ? CALC : DONE;
        end else begin
          state_nx = IDLE;
        end
      end
      CALC: begin
        if (cnt_r == CNT_LAST) begin
          state_nx = DONE;
        end else begin
          state_nx = CALC;
        end
      end
      DONE: begin
        if (accept_s) begin
          state_nx = go_calc_s ? CALC : DONE;
        end else if (out_ready) begin
          state_nx = IDLE;
        end else begin
          state_nx = DONE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Datapath: capture at accept, iterate in CALC, hold otherwise
  always_ff @(posedge clk) begin
    if (!resetn) begin
      result_r <= {DATA_W{1'b0}};
      dbz_r    <= 1'b0;
      cnt_r    <= {(SHAMT_W+1){1'b0}};
      kind_r   <= 7'd0;
      qneg_r   <= 1'b0;
      rneg_r   <= 1'b0;
      acc_r    <= {W2{1'b0}};
      opa_r    <= {W2{1'b0}};
      opb_r    <= {DATA_W{1'b0}};
    end else if (accept_s) begin
      cnt_r  <= {(SHAMT_W+1){1'b0}};
      kind_r <= alu_op[18:12];
      if (go_calc_s) begin
        dbz_r  <= 1'b0;
        qneg_r <= use_sign_s & (alu_src1[DATA_W-1] ^ alu_src2[DATA_W-1]);
        rneg_r <= sdiv_s & alu_src1[DATA_W-1];
        opb_r  <= mag2_s;
        if (is_mul_req_s) begin
          acc_r <= {W2{1'b0}};
          opa_r <= {{DATA_W{1'b0}}, mag1_s};
        end else begin
          acc_r <= {{DATA_W{1'b0}}, mag1_s};
          opa_r <= {W2{1'b0}};
        end
      end else begin
        result_r <= single_res_s;
        dbz_r    <= dbz_req_s;
      end
    end else if (state_r == CALC) begin
      cnt_r <= cnt_r + CNT_ONE;
      acc_r <= acc_nx_s;
      opa_r <= {opa_r[W2-2:0], 1'b0};
      opb_r <= step_mul_s ? {1'b0, opb_r[DATA_W-1:1]} : opb_r;
      if (cnt_r == CNT_LAST) begin
        result_r <= iter_res_s;
      end
    end
  end

endmodule

// File: tb/tb_alu_mdu.sv
// Self-checking bench for alu_mdu: directed cases, handshake/reset scenarios and
// randomized ops against an arithmetic reference model.
module tb_alu_mdu;
  logic        clk = 1'b0;
  logic        resetn, in_valid, in_ready, out_valid, out_ready, div_by_zero, busy;
  logic [18:0] alu_op;
  logic [31:0] alu_src1, alu_src2, alu_result;
  int n_cmp = 0;
  int n_err = 0;

`ifdef ALU_MDU_FAST_MUL_EN
  localparam int MUL_LAT  = 1;
  localparam int MUL_BUSY = 0;
`else
  localparam int MUL_LAT  = 33;
  localparam int MUL_BUSY = 32;
`endif

  alu_mdu #(.DATA_W(32)) dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .alu_src1(alu_src1), .alu_src2(alu_src2),
    .out_valid(out_valid), .out_ready(out_ready), .alu_result(alu_result),
    .div_by_zero(div_by_zero), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [18:0] op_vec(input int op);
    logic [18:0] v;
    v = 19'd0;
    if (op >= 0) v[op] = 1'b1;
    return v;
  endfunction

  // Reference: plain arithmetic on 64-bit values
  function automatic void ref_model(input int op, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] r, output logic z, output int lat);
    longint sa, sb;
    logic [63:0] ua, ub, t;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    z = 1'b0;
    lat = 1;
    t = 64'd0;
    case (op)
      0:  r = a + b;
      1:  r = a - b;
      2:  r = (sa < sb) ? 32'd1 : 32'd0;
      3:  r = (a < b) ? 32'd1 : 32'd0;
      4:  r = a & b;
      5:  r = ~(a | b);
      6:  r = a | b;
      7:  r = a ^ b;
      8:  r = a << b[4:0];
      9:  r = a >> b[4:0];
      10: begin t = 64'(sa >>> b[4:0]); r = t[31:0]; end
      11: r = {b[31:12], 12'h000};
      12: begin t = ua * ub; r = t[31:0]; lat = MUL_LAT; end
      13: begin t = 64'(sa * sb); r = t[63:32]; lat = MUL_LAT; end
      14: begin t = ua * ub; r = t[63:32]; lat = MUL_LAT; end
      15, 16, 17, 18: begin
        if (b == 32'd0) begin
          z = 1'b1;
          r = (op == 15 || op == 17) ? 32'hFFFF_FFFF : a;
        end else begin
          lat = 33;
          case (op)
            15:      t = 64'(sa / sb);
            16:      t = 64'(sa % sb);
            17:      t = ua / ub;
            default: t = ua % ub;
          endcase
          r = t[31:0];
        end
      end
      default: r = 32'd0;
    endcase
  endfunction

  // Issue one op at a negedge; returns at the negedge where out_valid is first seen
  task automatic do_op(input int op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] r, output logic z, output int lat, output logic acc);
    in_valid = 1'b1;
    alu_op   = op_vec(op);
    alu_src1 = a;
    alu_src2 = b;
    #1;
    acc = in_ready;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    alu_op   = 19'($urandom());
    alu_src1 = $urandom();
    alu_src2 = $urandom();
    lat = 0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = i;
        break;
      end
    end
    r = alu_result;
    z = div_by_zero;
  endtask

  task automatic test_reset();
    resetn = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    alu_op = 19'd0; alu_src1 = 32'd0; alu_src2 = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    #1;
    n_cmp++;
    if ({out_valid, busy, div_by_zero, in_ready} !== 4'b0001) begin
      n_err++;
      $display("FAIL reset_flags: got ov/busy/dbz/ir=%b want 0001", {out_valid, busy, div_by_zero, in_ready});
    end
    n_cmp++;
    if (alu_result !== 32'd0) begin
      n_err++;
      $display("FAIL reset_result: got %h want 00000000", alu_result);
    end
  endtask

  int          d_op  [17] = '{0, 1, 2, 3, 10, 11, 15, 16, 15, 16, 17, 18, 0, 12, 14, 13, -1};
  logic [31:0] d_a   [17] = '{32'h7FFFFFFF, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'd0,
                              32'hFFFFFFF9, 32'hFFFFFFF9, 32'h80000000, 32'h80000000, 32'h1234, 32'h1234,
                              32'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'd5};
  logic [31:0] d_b   [17] = '{32'd1, 32'd7, 32'd1, 32'd1, 32'd4, 32'h12345ABC, 32'd2, 32'd2,
                              32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd0, 32'd2, 32'hFFFFFFFF,
                              32'hFFFFFFFF, 32'h80000000, 32'd6};
  logic [31:0] d_r   [17] = '{32'h80000000, 32'hFFFFFFFE, 32'd1, 32'd0, 32'hF8000000, 32'h12345000,
                              32'hFFFFFFFD, 32'hFFFFFFFF, 32'h80000000, 32'd0, 32'hFFFFFFFF, 32'h1234,
                              32'd3, 32'd1, 32'hFFFFFFFE, 32'h40000000, 32'd0};
  logic        d_z   [17] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                              1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  int          d_lat [17] = '{1, 1, 1, 1, 1, 1, 33, 33, 33, 33, 1, 1, 1, MUL_LAT, MUL_LAT, MUL_LAT, 1};

  // Consecutive calls also exercise back-to-back accept from DONE (add then sub)
  task automatic test_directed();
    logic [31:0] r;
    logic z, acc;
    int lat;
    for (int i = 0; i < 17; i++) begin
      do_op(d_op[i], d_a[i], d_b[i], r, z, lat, acc);
      n_cmp++;
      if (r !== d_r[i] || z !== d_z[i]) begin
        n_err++;
        $display("FAIL directed_%0d op=%0d: got %h dbz=%b want %h dbz=%b", i, d_op[i], r, z, d_r[i], d_z[i]);
      end
      n_cmp++;
      if (lat !== d_lat[i] || acc !== 1'b1) begin
        n_err++;
        $display("FAIL directed_lat_%0d: got lat=%0d ready=%b want lat=%0d ready=1", i, lat, acc, d_lat[i]);
      end
    end
  endtask

  // Busy length for mul, then hold result under back-pressure with a pending request
  task automatic test_busy_hold();
    int nbusy = 0;
    in_valid = 1'b1; alu_op = op_vec(12); alu_src1 = 32'hFFFFFFFF; alu_src2 = 32'hFFFFFFFF;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (busy) nbusy++;
      if (out_valid) break;
    end
    n_cmp++;
    if (nbusy !== MUL_BUSY) begin
      n_err++;
      $display("FAIL busy_cycles: got %0d want %0d", nbusy, MUL_BUSY);
    end
    out_ready = 1'b0;
    in_valid = 1'b1; alu_op = op_vec(0); alu_src1 = 32'd3; alu_src2 = 32'd4;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_cmp++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || alu_result !== 32'd1) begin
        n_err++;
        $display("FAIL hold_%0d: got ov=%b ir=%b res=%h want 1 0 00000001", i, out_valid, in_ready, alu_result);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b1 || alu_result !== 32'd7) begin
      n_err++;
      $display("FAIL hold_release: got ov=%b res=%h want 1 00000007", out_valid, alu_result);
    end
  endtask

  task automatic test_reset_midcalc();
    logic [31:0] r;
    logic z, acc;
    int lat;
    in_valid = 1'b1; alu_op = op_vec(17); alu_src1 = 32'd100; alu_src2 = 32'd7;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL midcalc_busy: got %b want 1", busy);
    end
    resetn = 1'b0;
    @(posedge clk);
    #1;
    resetn = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({out_valid, busy, in_ready, div_by_zero} !== 4'b0010 || alu_result !== 32'd0) begin
      n_err++;
      $display("FAIL midcalc_reset: got ov/busy/ir/dbz=%b res=%h want 0010 00000000",
               {out_valid, busy, in_ready, div_by_zero}, alu_result);
    end
    do_op(17, 32'd100, 32'd7, r, z, lat, acc);
    n_cmp++;
    if (r !== 32'd14 || lat !== 33) begin
      n_err++;
      $display("FAIL post_reset_divu: got %h lat=%0d want 0000000e lat=33", r, lat);
    end
    do_op(18, 32'd100, 32'd7, r, z, lat, acc);
    n_cmp++;
    if (r !== 32'd2 || lat !== 33) begin
      n_err++;
      $display("FAIL post_reset_modu: got %h lat=%0d want 00000002 lat=33", r, lat);
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'hFFFFFFFF;
      3:       return 32'h80000000;
      4:       return 32'h7FFFFFFF;
      default: return $urandom();
    endcase
  endfunction

  task automatic test_random();
    logic [31:0] a, b, r, er;
    logic z, ez, acc;
    int op, lat, elat;
    for (int i = 0; i < 120; i++) begin
      op = int'($urandom_range(0, 19)) - 1;
      a = pick();
      b = pick();
      ref_model(op, a, b, er, ez, elat);
      do_op(op, a, b, r, z, lat, acc);
      n_cmp++;
      if (r !== er || z !== ez || lat !== elat || acc !== 1'b1) begin
        n_err++;
        $display("FAIL random_%0d op=%0d a=%h b=%h: got %h dbz=%b lat=%0d ready=%b want %h dbz=%b lat=%0d ready=1",
                 i, op, a, b, r, z, lat, acc, er, ez, elat);
      end
    end
  endtask

  initial begin
    test_reset();
    @(negedge clk);
    test_directed();
    test_busy_hold();
    test_reset_midcalc();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
